// File: rtl/exu_trap_pkg.sv
// Shared types and constants for the machine-mode trap/return sequencer.
package exu_trap_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_ISSUE = 2'd2
   } trap_state_e;

   typedef enum logic [1:0] {
      EVT_NONE = 2'd0,
      EVT_IRQ  = 2'd1,
      EVT_EXC  = 2'd2,
      EVT_MRET = 2'd3
   } evt_kind_e;

   localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
   localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
   localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
   localparam logic [31:0] IRQ_MSI       = 32'h8000_0003;
   localparam logic [31:0] IRQ_MTI       = 32'h8000_0007;
   localparam logic [31:0] IRQ_MEI       = 32'h8000_000B;

   localparam logic [1:0]  MTVEC_MODE_VEC = 2'b01;

   // Event captured at commit and held until it is issued to the CSR file.
   typedef struct packed {
      evt_kind_e   kind;
      logic [31:0] cause;
      logic [31:0] epc;
   } trap_evt_t;

   // Vectored offset applies only when the caller says the event may use it.
   function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                               input logic [31:0] cause,
                                               input logic        vec_ok);
      logic [31:0] base;
      base = {mtvec[31:2], 2'b00};
      if (vec_ok && (mtvec[1:0] == MTVEC_MODE_VEC))
         return base + {25'd0, cause[4:0], 2'b00};
      return base;
   endfunction

endpackage

// File: rtl/exu_trap_ctrl_if.sv
// Commit-stage handshake plus the CSR-update / redirect bus of the trap sequencer.
interface exu_trap_ctrl_if;
   logic        cmt_valid;
   logic [31:0] cmt_pc;
   logic        cmt_illegal;
   logic        cmt_ebreak;
   logic        cmt_ecall;
   logic        cmt_mret;
   logic        cmt_ready;

   logic        int_ena;
   logic [31:0] i_mcause;
   logic [31:0] epc_pc;
   logic        mret_ena;
   logic        flush;
   logic [31:0] flush_pc;
   logic        in_retr;

   modport master (
      output cmt_valid, cmt_pc, cmt_illegal, cmt_ebreak, cmt_ecall, cmt_mret,
      input  cmt_ready, int_ena, i_mcause, epc_pc, mret_ena, flush, flush_pc, in_retr
   );

   modport slave (
      input  cmt_valid, cmt_pc, cmt_illegal, cmt_ebreak, cmt_ecall, cmt_mret,
      output cmt_ready, int_ena, i_mcause, epc_pc, mret_ena, flush, flush_pc, in_retr
   );
endinterface

// File: rtl/exu_trap_prio.sv
// Combinational event priority: interrupts (MEI>MSI>MTI), then exceptions
// (illegal>ebreak>ecall), then MRET.
module exu_trap_prio
   import exu_trap_pkg::*;
(
   input  logic        status_mie,
   input  logic        mie_meie,
   input  logic        mie_msie,
   input  logic        mie_mtie,
   input  logic        mip_meip,
   input  logic        mip_msip,
   input  logic        mip_mtip,
   input  logic        illegal,
   input  logic        ebreak,
   input  logic        ecall,
   input  logic        mret,
   output logic        event_valid,
   output logic        is_irq,
   output logic        is_mret,
   output logic [31:0] cause
);

   // NOTE: every output gets a default before the if-chain so no path leaves
   // a variable unassigned, which would otherwise infer a latch.
   always_comb begin
      event_valid = 1'b0;
      is_irq      = 1'b0;
      is_mret     = 1'b0;
      cause       = '0;
      if (status_mie && mie_meie && mip_meip) begin
         event_valid = 1'b1;
         is_irq      = 1'b1;
         cause       = IRQ_MEI;
      end else if (status_mie && mie_msie && mip_msip) begin
         event_valid = 1'b1;
         is_irq      = 1'b1;
         cause       = IRQ_MSI;
      end else if (status_mie && mie_mtie && mip_mtip) begin
         event_valid = 1'b1;
         is_irq      = 1'b1;
         cause       = IRQ_MTI;
      end else if (illegal) begin
         event_valid = 1'b1;
         cause       = CAUSE_ILLEGAL;
      end else if (ebreak) begin
         event_valid = 1'b1;
         cause       = CAUSE_EBREAK;
      end else if (ecall) begin
         event_valid = 1'b1;
         cause       = CAUSE_ECALL_M;
      end else if (mret) begin
         event_valid = 1'b1;
         is_mret     = 1'b1;
      end
   end

endmodule

// File: rtl/exu_trap_ctrl.sv
// Trap/return sequencer: picks retire, interrupt, exception or MRET at commit,
// drains the LSU, then issues a one-cycle CSR-update and flush pulse.
module exu_trap_ctrl
   import exu_trap_pkg::*;
#(
   parameter bit VEC_EN = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   exu_trap_ctrl_if.slave        cmt,
   input  logic                  lsu_busy,
   input  logic                  status_mie,
   input  logic                  mie_meie,
   input  logic                  mie_msie,
   input  logic                  mie_mtie,
   input  logic                  mip_meip,
   input  logic                  mip_msip,
   input  logic                  mip_mtip,
   input  logic [31:0]           cmtvec,
   input  logic [31:0]           cmepc,
   output logic                  trap_busy
);

   trap_state_e state, state_nxt;
   trap_evt_t   evt_q, evt_nxt, evt_new, evt_go;

   logic        prio_valid, prio_irq, prio_mret;
   logic [31:0] prio_cause;
   logic        event_now, go_issue;

   logic        int_ena_q, int_ena_d;
   logic        mret_ena_q, mret_ena_d;
   logic        flush_q, flush_d;
   logic [31:0] mcause_q, mcause_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] flush_pc_q, flush_pc_d;

   exu_trap_prio u_prio (
      .status_mie  (status_mie),
      .mie_meie    (mie_meie),
      .mie_msie    (mie_msie),
      .mie_mtie    (mie_mtie),
      .mip_meip    (mip_meip),
      .mip_msip    (mip_msip),
      .mip_mtip    (mip_mtip),
      .illegal     (cmt.cmt_illegal),
      .ebreak      (cmt.cmt_ebreak),
      .ecall       (cmt.cmt_ecall),
      .mret        (cmt.cmt_mret),
      .event_valid (prio_valid),
      .is_irq      (prio_irq),
      .is_mret     (prio_mret),
      .cause       (prio_cause)
   );

   assign event_now = (state == ST_IDLE) && cmt.cmt_valid && prio_valid;

   always_comb begin
      evt_new       = '0;
      evt_new.cause = prio_cause;
      evt_new.epc   = cmt.cmt_pc;
      if (prio_irq)
         evt_new.kind = EVT_IRQ;
      else if (prio_mret)
         evt_new.kind = EVT_MRET;
      else
         evt_new.kind = EVT_EXC;
   end

   always_comb begin
      state_nxt     = state;
      evt_nxt       = evt_q;
      go_issue      = 1'b0;
      cmt.cmt_ready = 1'b0;
      case (state)
         ST_IDLE: begin
            cmt.cmt_ready = !event_now;
            if (event_now) begin
               evt_nxt   = evt_new;
               go_issue  = !lsu_busy;
               state_nxt = lsu_busy ? ST_DRAIN : ST_ISSUE;
            end
         end
         ST_DRAIN: begin
            if (!lsu_busy) begin
               go_issue  = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Entering ISSUE straight from IDLE uses the fresh event; from DRAIN the held one.
   assign evt_go = (state == ST_IDLE) ? evt_new : evt_q;

   always_comb begin
      int_ena_d  = 1'b0;
      mret_ena_d = 1'b0;
      flush_d    = 1'b0;
      mcause_d   = mcause_q;
      epc_d      = epc_q;
      flush_pc_d = flush_pc_q;
      if (go_issue) begin
         flush_d = 1'b1;
         if (evt_go.kind == EVT_MRET) begin
            mret_ena_d = 1'b1;
            flush_pc_d = cmepc;
         end else begin
            int_ena_d  = 1'b1;
            mcause_d   = evt_go.cause;
            epc_d      = evt_go.epc;
            flush_pc_d = trap_target(cmtvec, evt_go.cause,
                                     VEC_EN && (evt_go.kind == EVT_IRQ));
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         evt_q      <= '0;
         int_ena_q  <= 1'b0;
         mret_ena_q <= 1'b0;
         flush_q    <= 1'b0;
         mcause_q   <= '0;
         epc_q      <= '0;
         flush_pc_q <= '0;
      end else begin
         state      <= state_nxt;
         evt_q      <= evt_nxt;
         int_ena_q  <= int_ena_d;
         mret_ena_q <= mret_ena_d;
         flush_q    <= flush_d;
         mcause_q   <= mcause_d;
         epc_q      <= epc_d;
         flush_pc_q <= flush_pc_d;
      end
   end

   assign cmt.int_ena  = int_ena_q;
   assign cmt.mret_ena = mret_ena_q;
   assign cmt.flush    = flush_q;
   assign cmt.i_mcause = mcause_q;
   assign cmt.epc_pc   = epc_q;
   assign cmt.flush_pc = flush_pc_q;

   // MRET retires in its ISSUE cycle; excepting instructions never retire.
   assign cmt.in_retr  = ((state == ST_IDLE) && cmt.cmt_valid && !prio_valid) || mret_ena_q;
   assign trap_busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_exu_trap_ctrl.sv
// Randomized and directed checks of exu_trap_ctrl against a transaction-level model.
module tb_exu_trap_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        lsu_busy, status_mie;
   logic        mie_meie, mie_msie, mie_mtie;
   logic        mip_meip, mip_msip, mip_mtip;
   logic [31:0] cmtvec, cmepc;
   logic        trap_busy;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   exu_trap_ctrl_if cmt_if ();

   exu_trap_ctrl #(.VEC_EN(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmt        (cmt_if),
      .lsu_busy   (lsu_busy),
      .status_mie (status_mie),
      .mie_meie   (mie_meie),
      .mie_msie   (mie_msie),
      .mie_mtie   (mie_mtie),
      .mip_meip   (mip_meip),
      .mip_msip   (mip_msip),
      .mip_mtip   (mip_mtip),
      .cmtvec     (cmtvec),
      .cmepc      (cmepc),
      .trap_busy  (trap_busy)
   );

   always #5 clk = ~clk;

   // Model: an accepted trap is either waiting for the LSU or being issued now.
   bit          m_wait, m_issue, m_mret;
   logic [31:0] m_cause, m_epc, m_target;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void ref_event(output bit ev, output bit irq, output bit mret,
                                     output logic [31:0] cause);
      ev = 1; irq = 0; mret = 0; cause = 0;
      if (!cmt_if.cmt_valid)                          ev = 0;
      else if (status_mie && mie_meie && mip_meip) begin irq = 1; cause = 32'h8000_000B; end
      else if (status_mie && mie_msie && mip_msip) begin irq = 1; cause = 32'h8000_0003; end
      else if (status_mie && mie_mtie && mip_mtip) begin irq = 1; cause = 32'h8000_0007; end
      else if (cmt_if.cmt_illegal)                     cause = 2;
      else if (cmt_if.cmt_ebreak)                      cause = 3;
      else if (cmt_if.cmt_ecall)                       cause = 11;
      else if (cmt_if.cmt_mret)                        mret = 1;
      else                                             ev = 0;
   endfunction

   function automatic logic [31:0] ref_target(input bit irq, input bit mret, input logic [31:0] cause);
      logic [31:0] base;
      if (mret) return cmepc;
      base = cmtvec & ~32'h3;
      if (irq && cmtvec[1:0] == 2'b01) return base + (cause & 32'h1F) * 4;
      return base;
   endfunction

   task automatic compare_cycle();
      bit ev, irq, mret;
      logic [31:0] cause;
      if (m_issue) begin
         check("trap_busy", {31'd0, trap_busy}, 1);
         check("cmt_ready", {31'd0, cmt_if.cmt_ready}, 0);
         check("flush", {31'd0, cmt_if.flush}, 1);
         check("flush_pc", cmt_if.flush_pc, m_target);
         check("int_ena", {31'd0, cmt_if.int_ena}, {31'd0, !m_mret});
         check("mret_ena", {31'd0, cmt_if.mret_ena}, {31'd0, m_mret});
         check("in_retr", {31'd0, cmt_if.in_retr}, {31'd0, m_mret});
         if (!m_mret) begin
            check("i_mcause", cmt_if.i_mcause, m_cause);
            check("epc_pc", cmt_if.epc_pc, m_epc);
         end
      end else begin
         ref_event(ev, irq, mret, cause);
         check("trap_busy", {31'd0, trap_busy}, {31'd0, m_wait});
         check("cmt_ready", {31'd0, cmt_if.cmt_ready}, {31'd0, !m_wait && !ev});
         check("in_retr", {31'd0, cmt_if.in_retr},
               {31'd0, !m_wait && cmt_if.cmt_valid && !ev});
         check("pulses", {29'd0, cmt_if.flush, cmt_if.int_ena, cmt_if.mret_ena}, 0);
      end
   endtask

   task automatic model_update();
      bit ev, irq, mret;
      logic [31:0] cause;
      if (rst) begin
         m_wait = 0; m_issue = 0;
      end else if (m_issue) begin
         m_issue = 0;
      end else if (m_wait) begin
         if (!lsu_busy) begin
            m_wait = 0; m_issue = 1;
            m_target = ref_target(!m_mret && m_cause[31], m_mret, m_cause);
         end
      end else begin
         ref_event(ev, irq, mret, cause);
         if (ev) begin
            m_mret = mret; m_cause = cause; m_epc = cmt_if.cmt_pc;
            if (lsu_busy) m_wait = 1;
            else begin
               m_issue = 1;
               m_target = ref_target(irq, mret, cause);
            end
         end
      end
   endtask

   // Caller sets inputs after a negedge; outputs are checked before the posedge.
   task automatic step();
      #1;
      compare_cycle();
      model_update();
      @(negedge clk);
   endtask

   task automatic clr_in();
      cmt_if.cmt_valid = 0; cmt_if.cmt_pc = 0;
      cmt_if.cmt_illegal = 0; cmt_if.cmt_ebreak = 0;
      cmt_if.cmt_ecall = 0; cmt_if.cmt_mret = 0;
      lsu_busy = 0; status_mie = 0;
      mie_meie = 0; mie_msie = 0; mie_mtie = 0;
      mip_meip = 0; mip_msip = 0; mip_mtip = 0;
   endtask

   initial begin
      m_wait = 0; m_issue = 0; m_mret = 0; m_cause = 0; m_epc = 0; m_target = 0;
      clr_in();
      cmtvec = 32'h8000_0001; cmepc = 32'h300;
      rst = 1;
      @(negedge clk); @(negedge clk);
      rst = 0;
      #1;
      check("rst_mcause", cmt_if.i_mcause, 0);
      check("rst_epc", cmt_if.epc_pc, 0);
      check("rst_flush_pc", cmt_if.flush_pc, 0);
      check("rst_busy", {31'd0, trap_busy}, 0);
      step();

      // Plain retire stream
      cmt_if.cmt_valid = 1;
      for (int i = 0; i < 6; i++) begin
         cmt_if.cmt_pc = 32'h1000 + 4 * i;
         step();
      end

      // MEI beats MTI, vectored target
      status_mie = 1; mie_meie = 1; mie_mtie = 1; mip_meip = 1; mip_mtip = 1;
      cmt_if.cmt_pc = 32'h100;
      step();
      clr_in();
      #1;
      check("mei_int_ena", {31'd0, cmt_if.int_ena}, 1);
      check("mei_cause", cmt_if.i_mcause, 32'h8000_000B);
      check("mei_epc", cmt_if.epc_pc, 32'h100);
      check("mei_target", cmt_if.flush_pc, 32'h8000_002C);
      check("mei_retr", {31'd0, cmt_if.in_retr}, 0);
      step();

      // ECALL with a 3-cycle drain
      cmt_if.cmt_valid = 1; cmt_if.cmt_pc = 32'h200; cmt_if.cmt_ecall = 1; lsu_busy = 1;
      step(); step(); step();
      #1;
      check("drain_ready", {31'd0, cmt_if.cmt_ready}, 0);
      check("drain_busy", {31'd0, trap_busy}, 1);
      lsu_busy = 0;
      step();
      clr_in();
      #1;
      check("ecall_int_ena", {31'd0, cmt_if.int_ena}, 1);
      check("ecall_cause", cmt_if.i_mcause, 11);
      check("ecall_target", cmt_if.flush_pc, 32'h8000_0000);
      step();

      // MRET
      cmt_if.cmt_valid = 1; cmt_if.cmt_pc = 32'h280; cmt_if.cmt_mret = 1; cmepc = 32'h300;
      step();
      clr_in();
      #1;
      check("mret_ena", {31'd0, cmt_if.mret_ena}, 1);
      check("mret_flush_pc", cmt_if.flush_pc, 32'h300);
      check("mret_retr", {31'd0, cmt_if.in_retr}, 1);
      step();
      #1;
      check("mret_idle", {31'd0, trap_busy}, 0);

      // MRET colliding with MTI: interrupt wins
      cmt_if.cmt_valid = 1; cmt_if.cmt_pc = 32'h400; cmt_if.cmt_mret = 1;
      status_mie = 1; mie_mtie = 1; mip_mtip = 1;
      step();
      clr_in();
      #1;
      check("mti_int_ena", {31'd0, cmt_if.int_ena}, 1);
      check("mti_cause", cmt_if.i_mcause, 32'h8000_0007);
      check("mti_epc", cmt_if.epc_pc, 32'h400);
      check("mti_mret_ena", {31'd0, cmt_if.mret_ena}, 0);
      step();

      // Reset mid-DRAIN discards the event
      cmt_if.cmt_valid = 1; cmt_if.cmt_pc = 32'h500; cmt_if.cmt_illegal = 1; lsu_busy = 1;
      step(); step();
      rst = 1;
      step();
      rst = 0;
      clr_in();
      #1;
      check("rstd_busy", {31'd0, trap_busy}, 0);
      check("rstd_mcause", cmt_if.i_mcause, 0);
      check("rstd_flush_pc", cmt_if.flush_pc, 0);
      for (int i = 0; i < 3; i++) step();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         rst                = ($urandom_range(0, 63) == 0);
         cmt_if.cmt_valid   = ($urandom_range(0, 3) != 0);
         cmt_if.cmt_pc      = $urandom & ~32'h3;
         cmt_if.cmt_illegal = ($urandom_range(0, 11) == 0);
         cmt_if.cmt_ebreak  = ($urandom_range(0, 11) == 0);
         cmt_if.cmt_ecall   = ($urandom_range(0, 11) == 0);
         cmt_if.cmt_mret    = ($urandom_range(0, 9) == 0);
         lsu_busy           = ($urandom_range(0, 2) == 0);
         status_mie         = $urandom_range(0, 1);
         mie_meie = $urandom_range(0, 1); mie_msie = $urandom_range(0, 1);
         mie_mtie = $urandom_range(0, 1);
         mip_meip = ($urandom_range(0, 5) == 0); mip_msip = ($urandom_range(0, 5) == 0);
         mip_mtip = ($urandom_range(0, 5) == 0);
         cmtvec   = $urandom;
         cmepc    = $urandom;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
